// File: rtl/cpu_pkg.sv
// Shared widths, constants and the sequencing FSM encoding for the hazard controller.
package cpu_pkg;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned STATE_W = 3;

  localparam logic [REG_W-1:0] REG_ZERO          = 4'b0000;
  localparam logic [CNT_W-1:0] HALT_DRAIN_CYCLES = 2'd3;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_STALL  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_HALTED = 3'd3
  } ctrl_state_e;

  // Register r0 is hardwired, so it never creates a dependence.
  function automatic logic reg_match(input logic [REG_W-1:0] producer,
                                     input logic [REG_W-1:0] consumer);
    return (producer != REG_ZERO) && (producer == consumer);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard compare: returns the number of stall cycles the decode instruction needs.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             id_is_branch_reg_i,
  input  logic             id_is_branch_cond_i,
  input  logic             id_ex_mem_read_i,
  input  logic             id_ex_reg_write_i,
  input  logic             id_ex_sets_flags_i,
  input  logic [REG_W-1:0] id_ex_rd_i,
  input  logic             ex_mem_mem_read_i,
  input  logic [REG_W-1:0] ex_mem_rd_i,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic load_use_c;
  logic br_load_c;
  logic br_alu_c;
  logic br_mem_load_c;
  logic flag_dep_c;

  always_comb begin
    load_use_c    = id_ex_mem_read_i &&
                    ((id_uses_rs_i && reg_match(id_ex_rd_i, id_rs_i)) ||
                     (id_uses_rt_i && reg_match(id_ex_rd_i, id_rt_i)));
    // Register-indirect branches resolve in ID, so they need Rs a stage earlier.
    br_load_c     = id_is_branch_reg_i && id_ex_mem_read_i && reg_match(id_ex_rd_i, id_rs_i);
    br_alu_c      = id_is_branch_reg_i && id_ex_reg_write_i && !id_ex_mem_read_i &&
                    reg_match(id_ex_rd_i, id_rs_i);
    br_mem_load_c = id_is_branch_reg_i && ex_mem_mem_read_i && reg_match(ex_mem_rd_i, id_rs_i);
    flag_dep_c    = id_is_branch_cond_i && id_ex_sets_flags_i;

    stall_cnt_o = '0;
    if (br_load_c) begin
      stall_cnt_o = CNT_W'(2);
    end else if (load_use_c || br_alu_c || br_mem_load_c || flag_dep_c) begin
      stall_cnt_o = CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing FSM: hazard stalls, taken-branch flush and halt drain.
module pipeline_hazard_ctrl
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_W-1:0]   ID_Rs,
  input  logic [REG_W-1:0]   ID_Rt,
  input  logic               ID_UsesRs,
  input  logic               ID_UsesRt,
  input  logic               ID_IsBranchReg,
  input  logic               ID_IsBranchCond,
  input  logic               ID_IsHalt,
  input  logic               BranchTaken,
  input  logic               ID_EX_MemRead,
  input  logic               ID_EX_RegWrite,
  input  logic               ID_EX_SetsFlags,
  input  logic [REG_W-1:0]   ID_EX_Rd,
  input  logic               EX_MEM_MemRead,
  input  logic [REG_W-1:0]   EX_MEM_Rd,
  output logic               PC_Stall,
  output logic               IF_ID_Stall,
  output logic               ID_EX_Bubble,
  output logic               IF_ID_Flush,
  output logic               Halted,
  output logic [STATE_W-1:0] CtrlState
);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] need_cnt;
  logic             pc_stall_c, if_id_stall_c, bubble_c, flush_c, halted_c;

  hazard_detect u_hazard_detect (
    .id_rs_i             (ID_Rs),
    .id_rt_i             (ID_Rt),
    .id_uses_rs_i        (ID_UsesRs),
    .id_uses_rt_i        (ID_UsesRt),
    .id_is_branch_reg_i  (ID_IsBranchReg),
    .id_is_branch_cond_i (ID_IsBranchCond),
    .id_ex_mem_read_i    (ID_EX_MemRead),
    .id_ex_reg_write_i   (ID_EX_RegWrite),
    .id_ex_sets_flags_i  (ID_EX_SetsFlags),
    .id_ex_rd_i          (ID_EX_Rd),
    .ex_mem_mem_read_i   (EX_MEM_MemRead),
    .ex_mem_rd_i         (EX_MEM_Rd),
    .stall_cnt_o         (need_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Priority in RUN: hazard stall, then taken-branch flush, then halt.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    bubble_c      = 1'b0;
    flush_c       = 1'b0;
    halted_c      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (need_cnt != '0) begin
          pc_stall_c    = 1'b1;
          if_id_stall_c = 1'b1;
          bubble_c      = 1'b1;
          if (need_cnt == CNT_W'(2)) begin
            state_d = ST_STALL;
            cnt_d   = CNT_W'(1);
          end
        end else if (BranchTaken) begin
          flush_c = 1'b1;
        end else if (ID_IsHalt) begin
          pc_stall_c = 1'b1;
          state_d    = ST_DRAIN;
          cnt_d      = HALT_DRAIN_CYCLES;
        end
      end
      ST_STALL: begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        bubble_c      = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        pc_stall_c = 1'b1;
        bubble_c   = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        pc_stall_c    = 1'b1;
        if_id_stall_c = 1'b1;
        halted_c      = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are gated by reset so they read 0 even while hazard inputs are active.
  assign PC_Stall     = rst_n & pc_stall_c;
  assign IF_ID_Stall  = rst_n & if_id_stall_c;
  assign ID_EX_Bubble = rst_n & bubble_c;
  assign IF_ID_Flush  = rst_n & flush_c;
  assign Halted       = rst_n & halted_c;
  assign CtrlState    = rst_n ? STATE_W'(state_q) : '0;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have ports ID_Rs and ID_Rt, input, 4 each: source registers of the instruction in decode.
REQ-004 SHALL have ports ID_UsesRs and ID_UsesRt, input, 1 each: the decode instruction reads Rs/Rt.
REQ-005 SHALL have ports ID_IsBranchReg, ID_IsBranchCond and ID_IsHalt, input, 1 each: decode instruction class.
REQ-006 SHALL have port BranchTaken, input, 1: branch resolved taken in ID this cycle.
REQ-007 SHALL have ports ID_EX_MemRead, ID_EX_RegWrite and ID_EX_SetsFlags, input, 1 each; ID_EX_Rd, input, 4.
REQ-008 SHALL have port EX_MEM_MemRead, input, 1, and EX_MEM_Rd, input, 4.
REQ-009 SHALL have ports PC_Stall, IF_ID_Stall, ID_EX_Bubble and IF_ID_Flush, output, 1 each: pipeline sequencing controls.
REQ-010 SHALL have port Halted, output, 1, and CtrlState, output, 3: current FSM state, for debug.

Function
REQ-011 SHALL implement FSM states RUN, STALL, DRAIN and HALTED.
REQ-012 SHALL treat register 4'b0000 as never matching any hazard compare.
REQ-013 SHALL detect load-use: ID_EX_MemRead with ID_EX_Rd matching a used Rs/Rt -> stall count 1.
REQ-014 SHALL detect BR dependence on Rs: ID_EX_MemRead match -> 2; ID_EX_RegWrite non-load match -> 1; EX_MEM_MemRead match -> 1.
REQ-015 SHALL detect flag dependence: ID_IsBranchCond with ID_EX_SetsFlags -> stall count 1.
REQ-016 SHALL use the maximum count when multiple hazards are detected in the same cycle.
REQ-017 SHALL, in RUN with count N>0, assert PC_Stall, IF_ID_Stall and ID_EX_Bubble combinationally that cycle; if N=2, go to STALL with counter=1; if N=1, stay in RUN.
REQ-018 SHALL, in STALL, assert PC_Stall, IF_ID_Stall and ID_EX_Bubble, ignore hazard inputs, decrement the counter, and return to RUN when the counter reaches 0.
REQ-019 SHALL assert IF_ID_Flush for one cycle when in RUN with BranchTaken and no hazard; a hazard in the same cycle masks BranchTaken.
REQ-020 SHALL, on ID_IsHalt in RUN with no hazard and no taken branch, enter DRAIN with counter=3 and hold PC_Stall=1 from that cycle onward.
REQ-021 SHALL, in DRAIN, hold PC_Stall=1 and ID_EX_Bubble=1, decrement the counter each cycle, and enter HALTED when it reaches 0.
REQ-022 SHALL, in HALTED, hold PC_Stall=1, IF_ID_Stall=1 and Halted=1 until reset, with no exit otherwise.
REQ-023 SHALL apply priority: hazard stall > taken-branch flush > halt.
REQ-024 SHALL use a 2-bit counter that never wraps; a decrement at 0 is illegal and SHALL NOT occur.

Reset
REQ-025 SHALL, on rst_n low, set the state to RUN and the counter to 0 immediately, and force all outputs to 0 regardless of inputs.
REQ-026 SHALL abandon any STALL or DRAIN in progress on reset mid-operation; the first cycle after deassertion is RUN.

Structure
REQ-027 SHALL take state encodings, REG_ZERO=4'b0000 and HALT_DRAIN_CYCLES=3 from the shared package cpu_pkg.
REQ-028 SHALL place all compare logic (REQ-012..016) in a combinational sub-module hazard_detect that outputs the 2-bit required count; the FSM resides in pipeline_hazard_ctrl.

Verification
REQ-029 Load-use: ID_EX_MemRead=1, ID_EX_Rd=5, ID_Rs=5, ID_UsesRs=1 -> exactly 1 cycle of PC_Stall/IF_ID_Stall/ID_EX_Bubble, then RUN.
REQ-030 BR after load: ID_IsBranchReg=1, ID_Rs=3, ID_EX_MemRead=1, ID_EX_Rd=3 -> 2 consecutive stall cycles (RUN->STALL->RUN).
REQ-031 Zero register: ID_EX_MemRead=1, ID_EX_Rd=0, ID_Rs=0 -> no stall.
REQ-032 Branch vs hazard: BranchTaken=1 with a flag hazard -> stall 1 cycle with IF_ID_Flush=0; next cycle BranchTaken=1, no hazard -> IF_ID_Flush=1 for 1 cycle.
REQ-033 Halt: ID_IsHalt=1 in RUN -> 3 DRAIN cycles, then Halted=1 held; rst_n pulse low -> Halted=0 and CtrlState=RUN.
REQ-034 Reset mid-STALL: rst_n low during STALL -> outputs 0 immediately and RUN after release.
